// File: rtl/ser_tx_scheduler_pkg.sv
// Shared types and constants for the serializer transmit scheduler.
package ser_tx_scheduler_pkg;

    localparam int SYM_W   = 9;
    localparam int NUM_SYM = 3;
    localparam int FRAME_W = NUM_SYM * SYM_W;
    localparam int K_BIT   = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_GAP  = 2'd2
    } sched_state_t;

    // K flag of symbol s within a frame.
    function automatic logic sym_k(input logic [FRAME_W-1:0] f, input int unsigned s);
        return f[s*SYM_W + K_BIT];
    endfunction

endpackage

// File: rtl/ser_tx_scheduler_if.sv
// Requester / serializer bundle for the transmit scheduler.
interface ser_tx_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int FRAME_W = ser_tx_scheduler_pkg::FRAME_W
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic                       enable_i;
    logic [NUM_REQ-1:0]         req_i;
    logic [NUM_REQ*FRAME_W-1:0] frame_i;
    logic [NUM_REQ-1:0]         ack_o;
    logic [NUM_REQ-1:0]         err_o;
    logic [FRAME_W-1:0]         ser_data_o;
    logic                       ser_start_o;
    logic                       ser_done_i;
    logic                       busy_o;
    logic [IDX_W-1:0]           grant_id_o;
    logic [15:0]                frame_cnt_o;

    modport slave (
        input  enable_i, req_i, frame_i, ser_done_i,
        output ack_o, err_o, ser_data_o, ser_start_o, busy_o, grant_id_o, frame_cnt_o
    );

    modport master (
        output enable_i, req_i, frame_i, ser_done_i,
        input  ack_o, err_o, ser_data_o, ser_start_o, busy_o, grant_id_o, frame_cnt_o
    );

endinterface

// File: rtl/ser_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: search upward from ptr_i+1 with wrap.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);
    localparam int unsigned NR_U = NUM_REQ;

    int unsigned cand;

    // First active request after the last winner gets the one-hot grant.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int unsigned i = 1; i <= NR_U; i++) begin
            cand = (32'(ptr_i) + i) % NR_U;
            if (!valid_o && req_i[cand[IDX_W-1:0]]) begin
                valid_o                  = 1'b1;
                gnt_o[cand[IDX_W-1:0]]   = 1'b1;
                idx_o                    = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/ser_tx_scheduler.sv
// Round-robin scheduler sharing one serializer transmit channel between requesters.
module ser_tx_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int FRAME_W = ser_tx_scheduler_pkg::FRAME_W,
    parameter int TIMEOUT = 1023,
    parameter int GAP_CYC = 2
) (
    input logic               CLK_I,
    input logic               RST_I,
    ser_tx_scheduler_if.slave bus
);
    import ser_tx_scheduler_pkg::*;

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int CNT_MAX = (TIMEOUT > GAP_CYC) ? TIMEOUT : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    sched_state_t       state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   gid_q, gid_d;
    logic [FRAME_W-1:0] data_q, data_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [NUM_REQ-1:0] err_q, err_d;
    logic [15:0]        fcnt_q, fcnt_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;
    logic [FRAME_W-1:0] frame_sel;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i   (bus.req_i),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // One-hot AND-OR select of the winning requester's frame.
    always_comb begin
        frame_sel = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (arb_gnt[k]) frame_sel = frame_sel | bus.frame_i[k*FRAME_W +: FRAME_W];
        end
    end

    // Next-state logic: grant in IDLE, wait for done or timeout, then hold the gap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        data_d  = data_q;
        ack_d   = '0;
        err_d   = '0;
        fcnt_d  = fcnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.enable_i && arb_valid) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                    ptr_d   = arb_idx;
                    gid_d   = arb_idx;
                    data_d  = frame_sel;
                end
            end
            S_WAIT: begin
                if (bus.ser_done_i) begin
                    ack_d[gid_q] = 1'b1;
                    fcnt_d       = fcnt_q + 16'd1;
                    state_d      = S_GAP;
                    cnt_d        = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d[gid_q] = 1'b1;
                    state_d      = S_GAP;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            gid_q   <= '0;
            data_q  <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign bus.ack_o       = ack_q;
    assign bus.err_o       = err_q;
    assign bus.ser_data_o  = data_q;
    assign bus.ser_start_o = (state_q == S_WAIT);
    assign bus.busy_o      = (state_q != S_IDLE);
    assign bus.grant_id_o  = gid_q;
    assign bus.frame_cnt_o = fcnt_q;

endmodule

// File: tb/tb_ser_tx_scheduler.sv
// Self-checking bench for ser_tx_scheduler against a transaction-level model.
module tb_ser_tx_scheduler;

    localparam int NR  = 4;
    localparam int FW  = 27;
    localparam int TO  = 1023;
    localparam int GAP = 2;
    localparam int IW  = $clog2(NR);

    logic clk;
    logic rst;
    int   vec;
    int   errs;
    int   m_ptr;
    logic [15:0] m_cnt;

    ser_tx_scheduler_if #(.NUM_REQ(NR), .FRAME_W(FW)) bif ();

    ser_tx_scheduler #(
        .NUM_REQ (NR),
        .FRAME_W (FW),
        .TIMEOUT (TO),
        .GAP_CYC (GAP)
    ) dut (
        .CLK_I (clk),
        .RST_I (rst),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic int rr_pick(input logic [NR-1:0] r, input int p);
        for (int k = 1; k <= NR; k++) begin
            int c;
            c = (p + k) % NR;
            if (r[c]) return c;
        end
        return 0;
    endfunction

    task automatic rand_frames();
        for (int k = 0; k < NR; k++) bif.frame_i[k*FW +: FW] = FW'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bif.enable_i = 1'b0;
        bif.req_i = '0;
        bif.ser_done_i = 1'b0;
        rand_frames();
        tick();
        tick();
        rst = 1'b0;
        m_ptr = NR - 1;
        m_cnt = '0;
    endtask

    // One full transfer from an IDLE cycle: grant, WAIT, completion, gap, back to IDLE.
    // done_at = WAIT cycle carrying ser_done_i (0 = never).
    task automatic xfer(input logic [NR-1:0] req, input int done_at, input bit keep_req,
                        input bit drop_req, input bit drop_en);
        int w;
        bit ok;
        bit done_seen;
        logic [FW-1:0] exp_data;
        logic [NR-1:0] exp_ack;
        logic [NR-1:0] exp_err;
        w = rr_pick(req, m_ptr);
        exp_data = bif.frame_i[w*FW +: FW];
        bif.enable_i = 1'b1;
        bif.req_i = req;
        tick();
        vec++;
        if (bif.ser_start_o !== 1'b1 || bif.busy_o !== 1'b1 || bif.grant_id_o !== IW'(w)
            || bif.ser_data_o !== exp_data) begin
            errs++;
            $display("FAIL grant: start=%0b busy=%0b id=%0d data=%h, required start=1 busy=1 id=%0d data=%h",
                     bif.ser_start_o, bif.busy_o, bif.grant_id_o, bif.ser_data_o, w, exp_data);
        end
        rand_frames();
        if (drop_req) bif.req_i = '0;
        if (drop_en) bif.enable_i = 1'b0;
        ok = 1'b1;
        done_seen = 1'b0;
        for (int c = 1; c <= TO; c++) begin
            if (bif.ser_start_o !== 1'b1 || bif.ack_o !== '0 || bif.err_o !== '0
                || bif.ser_data_o !== exp_data) ok = 1'b0;
            if (c == done_at) begin
                bif.ser_done_i = 1'b1;
                tick();
                bif.ser_done_i = 1'b0;
                done_seen = 1'b1;
                break;
            end
            tick();
        end
        vec++;
        if (!ok) begin
            errs++;
            $display("FAIL wait_hold: start/ack/err/data changed during WAIT, required start=1 ack=0 err=0 data=%h",
                     exp_data);
        end
        exp_ack = '0;
        exp_err = '0;
        if (done_seen) begin
            exp_ack[w] = 1'b1;
            m_cnt = m_cnt + 16'd1;
        end else begin
            exp_err[w] = 1'b1;
        end
        m_ptr = w;
        vec++;
        if (bif.ack_o !== exp_ack || bif.err_o !== exp_err || bif.ser_start_o !== 1'b0
            || bif.frame_cnt_o !== m_cnt) begin
            errs++;
            $display("FAIL completion: ack=%b err=%b start=%0b cnt=%h, required ack=%b err=%b start=0 cnt=%h",
                     bif.ack_o, bif.err_o, bif.ser_start_o, bif.frame_cnt_o, exp_ack, exp_err, m_cnt);
        end
        if (!keep_req && !drop_req) bif.req_i[w] = 1'b0;
        ok = 1'b1;
        for (int g = 1; g <= GAP; g++) begin
            if (g > 1 && (bif.ack_o !== '0 || bif.err_o !== '0)) ok = 1'b0;
            if (bif.ser_start_o !== 1'b0 || bif.busy_o !== 1'b1 || bif.ser_data_o !== exp_data) ok = 1'b0;
            bif.ser_done_i = 1'($urandom_range(0, 1));
            tick();
        end
        bif.ser_done_i = 1'b0;
        vec++;
        if (!ok || bif.busy_o !== 1'b0 || bif.ser_start_o !== 1'b0 || bif.ack_o !== '0
            || bif.err_o !== '0 || bif.frame_cnt_o !== m_cnt) begin
            errs++;
            $display("FAIL gap: gap_ok=%0b busy=%0b start=%0b ack=%b err=%b cnt=%h, required gap_ok=1 busy=0 start=0 ack=0 err=0 cnt=%h",
                     ok, bif.busy_o, bif.ser_start_o, bif.ack_o, bif.err_o, bif.frame_cnt_o, m_cnt);
        end
    endtask

    task automatic test_reset();
        do_reset();
        vec++;
        if (bif.ser_start_o !== 1'b0 || bif.busy_o !== 1'b0 || bif.ack_o !== '0 || bif.err_o !== '0
            || bif.ser_data_o !== '0 || bif.grant_id_o !== '0 || bif.frame_cnt_o !== '0) begin
            errs++;
            $display("FAIL reset: start=%0b busy=%0b ack=%b err=%b data=%h id=%0d cnt=%h, required all zero",
                     bif.ser_start_o, bif.busy_o, bif.ack_o, bif.err_o, bif.ser_data_o,
                     bif.grant_id_o, bif.frame_cnt_o);
        end
    endtask

    task automatic test_basic();
        bif.frame_i[0 +: FW] = 27'h155AA3C;
        xfer(4'b0001, 10, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            rand_frames();
            xfer('1, int'($urandom_range(1, 8)), 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic test_timeout();
        logic [NR-1:0] r;
        r = NR'($urandom_range(3, (1 << NR) - 1));
        rand_frames();
        xfer(r, 0, 1'b1, 1'b0, 1'b0);
        rand_frames();
        xfer(r, 5, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_coincident();
        rand_frames();
        xfer(4'b0110, TO, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        int w;
        do_reset();
        xfer('1, 2, 1'b1, 1'b0, 1'b0);
        w = rr_pick('1, m_ptr);
        bif.enable_i = 1'b1;
        bif.req_i = '1;
        tick();
        vec++;
        if (bif.ser_start_o !== 1'b1 || bif.grant_id_o !== IW'(w)) begin
            errs++;
            $display("FAIL mid_grant: start=%0b id=%0d, required start=1 id=%0d",
                     bif.ser_start_o, bif.grant_id_o, w);
        end
        repeat (3) tick();
        rst = 1'b1;
        tick();
        vec++;
        if (bif.ser_start_o !== 1'b0 || bif.busy_o !== 1'b0 || bif.ack_o !== '0 || bif.err_o !== '0
            || bif.frame_cnt_o !== '0 || bif.grant_id_o !== '0) begin
            errs++;
            $display("FAIL mid_reset: start=%0b busy=%0b ack=%b err=%b cnt=%h id=%0d, required all zero",
                     bif.ser_start_o, bif.busy_o, bif.ack_o, bif.err_o, bif.frame_cnt_o, bif.grant_id_o);
        end
        rst = 1'b0;
        m_ptr = NR - 1;
        m_cnt = '0;
        rand_frames();
        xfer('1, 4, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_enable();
        bit ok;
        logic [NR-1:0] r;
        r = NR'($urandom_range(1, (1 << NR) - 1));
        bif.enable_i = 1'b0;
        bif.req_i = r;
        ok = 1'b1;
        repeat (5) begin
            tick();
            if (bif.busy_o !== 1'b0 || bif.ser_start_o !== 1'b0) ok = 1'b0;
        end
        vec++;
        if (!ok) begin
            errs++;
            $display("FAIL enable_block: grant seen with enable low, required busy=0 start=0");
        end
        rand_frames();
        xfer(r, 3, 1'b1, 1'b0, 1'b1);
        ok = 1'b1;
        repeat (4) begin
            tick();
            if (bif.busy_o !== 1'b0 || bif.ser_start_o !== 1'b0) ok = 1'b0;
        end
        vec++;
        if (!ok) begin
            errs++;
            $display("FAIL enable_idle: grant after enable dropped, required busy=0 start=0");
        end
    endtask

    task automatic test_req_drop();
        rand_frames();
        xfer(NR'($urandom_range(1, (1 << NR) - 1)), 6, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            rand_frames();
            xfer(NR'($urandom_range(1, (1 << NR) - 1)), int'($urandom_range(1, 12)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 1'b0);
        end
    endtask

    task automatic test_wrap();
        force dut.fcnt_q = 16'hFFFE;
        #1;
        release dut.fcnt_q;
        m_cnt = 16'hFFFE;
        rand_frames();
        xfer(4'b1000, 3, 1'b0, 1'b0, 1'b0);
        rand_frames();
        xfer(4'b0100, 2, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        vec = 0;
        errs = 0;
        rst = 1'b1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_timeout();
        test_coincident();
        test_reset_mid();
        test_enable();
        test_req_drop();
        test_random();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
